// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: the master drives the controls,
// the counter (slave) returns count, tc and ovf.
interface mod_counter_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up;
  logic [WIDTH-1:0] max_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, clr, load, load_val, up, max_val, ovf_clr,
    input  count, tc, ovf
  );

  modport slave (
    input  en, clr, load, load_val, up, max_val, ovf_clr,
    output count, tc, ovf
  );
endinterface

// File: rtl/mod_counter.sv
// Prescaled up/down modulo counter with a live upper limit, wrap or
// saturate at the boundary, a one-cycle terminal-count pulse and a sticky
// boundary flag. Priority each cycle: clr > load > step > hold.
module mod_counter #(
  parameter int WIDTH = 32,
  parameter int DIV   = 1,
  parameter int SAT   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_counter_if.slave  bus
);

  localparam bit SATURATE = (SAT != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             bnd;

  generate
    if (DIV == 1) begin : g_nopre
      // Every enabled cycle is a step; no prescaler state at all.
      assign step = bus.en;
    end else begin : g_pre
      localparam int PW = $clog2(DIV);
      logic [PW-1:0] pre_q, pre_d;

      // Prescaler walks 0..DIV-1 on enabled cycles; clr/load restart it.
      always_comb begin
        pre_d = pre_q;
        if (bus.clr || bus.load)
          pre_d = '0;
        else if (bus.en)
          pre_d = (pre_q == PW'(DIV - 1)) ? '0 : pre_q + PW'(1);
      end

      // Prescaler register; reset discards any partial period.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
      end

      assign step = bus.en && (pre_q == PW'(DIV - 1));
    end
  endgenerate

  // Next count and boundary detection. A boundary is only a step taken at
  // the limit (>= max_val going up, 0 going down), never a clr or load.
  always_comb begin
    count_d = count_q;
    bnd     = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (step) begin
      if (bus.up) begin
        if (count_q < bus.max_val) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          bnd     = 1'b1;
          count_d = SATURATE ? count_q : '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          bnd     = 1'b1;
          count_d = SATURATE ? '0 : bus.max_val;
        end
      end
    end
    tc_d  = bnd;
    // A boundary in the same cycle as ovf_clr wins so no event is lost.
    ovf_d = bnd | (ovf_q & ~bus.ovf_clr);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, counter width in bits (legal 2..64).
REQ-002 SHALL provide parameter DIV, default 1, prescale ratio: one count step per DIV enabled cycles (legal 1..65535).
REQ-003 SHALL provide parameter SAT, default 0, boundary mode: 0 = wrap, 1 = saturate.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable; gates the prescaler and the step.
REQ-007 clr  input  1  synchronous clear of count and prescaler.
REQ-008 load  input  1  synchronous load of load_val into count.
REQ-009 load_val  input  WIDTH  value written by load.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 max_val  input  WIDTH  inclusive upper limit (modulus minus one), sampled live every cycle.
REQ-012 ovf_clr  input  1  clears sticky ovf.
REQ-013 count  output  WIDTH  registered counter value.
REQ-014 tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 ovf  output  1  registered sticky boundary-event flag.

Function
REQ-016 Priority per cycle SHALL be clr > load > step > hold.
REQ-017 clr SHALL set count = 0 and prescaler = 0; tc = 0 that cycle.
REQ-018 load (clr low) SHALL set count = load_val and prescaler = 0; tc = 0; no range check against max_val.
REQ-019 Prescaler SHALL count 0..DIV-1 on cycles with en = 1, hold when en = 0, and issue a step when en = 1 and prescaler = DIV-1, then return to 0.
REQ-020 With DIV = 1, a step SHALL occur on every cycle with en = 1, with no prescaler register inferred.
REQ-021 Up step: count < max_val -> count + 1; count >= max_val -> 0 (SAT = 0) or unchanged (SAT = 1).
REQ-022 Down step: count > 0 -> count - 1; count = 0 -> max_val (SAT = 0) or 0 (SAT = 1).
REQ-023 A boundary event SHALL be a step taken under the >= max_val (up) or = 0 (down) condition of REQ-021/022.
REQ-024 tc SHALL be 1 in the cycle following a boundary event, 0 otherwise; under SAT = 1 it pulses once per blocked step.
REQ-025 ovf SHALL set on a boundary event and clear on ovf_clr; simultaneous set and ovf_clr -> ovf = 1.
REQ-026 Arithmetic SHALL be unsigned modulo 2^WIDTH; max_val = 2^WIDTH-1 with SAT = 0 gives plain binary wrap.
REQ-027 Count above max_val (after load or max_val lowered) SHALL wrap to 0 on the next up step (SAT = 0) or hold (SAT = 1).
REQ-028 Changing up mid-count SHALL take effect on the next step with no lost or duplicated step.
REQ-029 en = 0 SHALL freeze count and prescaler; clr and load SHALL act regardless of en.
REQ-030 Latency: count SHALL reflect any clr/load/step one clock after the sampling edge.

Reset
REQ-031 rst_n = 0 SHALL immediately force count = 0, prescaler = 0, tc = 0, ovf = 0, independent of clk.
REQ-032 Assertion mid-operation SHALL discard any partial prescale period; first step after release needs a full DIV enabled cycles.
REQ-033 Release SHALL be synchronous-safe: first update occurs at the first rising clk edge with rst_n = 1.

Verification
REQ-034 WIDTH=4, DIV=1, SAT=0, max_val=9, up=1, en=1, 12 cycles -> count 1..9,0,1,2; tc high exactly one cycle after the 9->0 step; ovf=1.
REQ-035 WIDTH=8, DIV=3, up=1, en toggled 1,1,0,1 repeatedly -> count increments once per 3 enabled cycles; holds across en=0.
REQ-036 SAT=1, max_val=5, load_val=4, load then 3 up steps -> count 5,5,5; tc pulses twice; ovf=1; then up=0 -> 4,3.
REQ-037 SAT=0, up=0, count=0, max_val=200 -> 200 after one step; clr and load same cycle with load_val=7 -> count=0.
REQ-038 rst_n pulled low between clk edges at count=0x55, ovf=1 -> count=0, ovf=0, tc=0 before the next edge; ovf_clr with coincident boundary event -> ovf stays 1.
